ball_engine: RTL

- Owns the Pong ball: position, velocity, wall and paddle bounces, and the serve/score state machine.
- Emits the `player_1_scored` / `player_2_scored` pulses that `score_board`-style counters edge-detect.
- Consumes the resulting `player_1_win` / `player_2_win` flags to freeze play.
- Renders the ball as a square pixel layer for the frame compositor, in the same `hpos`/`vpos` raster domain as the score and paddle layers.

---
 rtl/ball_engine_if.sv | 30 +++
 rtl/ball_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ball_engine_if.sv
// Game/raster bus of the Pong ball engine: frame sync, serve, paddles and
// win flags in; ball position, scored pulses and the ball pixel layer out.
interface ball_engine_if;
    logic               fsync;
    logic               serve;
    logic signed [11:0] paddle_1_vpos;
    logic signed [11:0] paddle_2_vpos;
    logic               player_1_win;
    logic               player_2_win;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               player_1_scored;
    logic               player_2_scored;
    logic signed [11:0] ball_x;
    logic signed [11:0] ball_y;
    logic               active;
    logic [7:0]         pixel [0:2];

    modport master (
        output fsync, serve, paddle_1_vpos, paddle_2_vpos,
               player_1_win, player_2_win, hpos, vpos,
        input  player_1_scored, player_2_scored, ball_x, ball_y, active, pixel
    );

    modport slave (
        input  fsync, serve, paddle_1_vpos, paddle_2_vpos,
               player_1_win, player_2_win, hpos, vpos,
        output player_1_scored, player_2_scored, ball_x, ball_y, active, pixel
    );
endinterface

// File: rtl/ball_engine.sv
// Pong ball: motion, wall/paddle bounces, serve/score FSM and pixel layer.
// Optional macro BALL_SPEEDUP_EN: each paddle hit raises |dx| up to BALL_SPEED_MAX.
module ball_engine #(
    parameter int          HRES           = 1280,
    parameter int          VRES           = 720,
    parameter int          BALL_SIZE      = 16,
    parameter int          BALL_SPEED     = 4,
    parameter int          BALL_SPEED_MAX = 12,
    parameter int          PADDLE_LEN     = 200,
    parameter int          PADDLE_THICK   = 20,
    parameter int          PADDLE_GAP     = 20,
    parameter int          SERVE_DELAY    = 60,
    parameter logic [23:0] COLOR          = 24'hFFFFFF
) (
    input logic          pixel_clk,
    input logic          rst,
    ball_engine_if.slave bus
);
    localparam int CW       = $clog2(SERVE_DELAY + 1);
    localparam int SPD_INIT = (BALL_SPEED < BALL_SPEED_MAX) ? BALL_SPEED : BALL_SPEED_MAX;

    localparam logic signed [12:0] S_ZERO = '0;
    localparam logic signed [12:0] S_BS   = 13'(BALL_SIZE);
    localparam logic signed [12:0] S_HRES = 13'(HRES);
    localparam logic signed [12:0] S_VRES = 13'(VRES);
    localparam logic signed [12:0] S_PL   = 13'(PADDLE_LEN);
    localparam logic signed [12:0] S_FL   = 13'(PADDLE_GAP + PADDLE_THICK);
    localparam logic signed [12:0] S_FR   = 13'(HRES - PADDLE_GAP - PADDLE_THICK);
    localparam logic signed [12:0] S_DY   = 13'(BALL_SPEED);
    localparam logic [11:0] CX    = 12'((HRES - BALL_SIZE) / 2);
    localparam logic [11:0] CY    = 12'((VRES - BALL_SIZE) / 2);
    localparam logic [11:0] Y_MAX = 12'(VRES - BALL_SIZE);
    localparam logic [11:0] X_L   = 12'(PADDLE_GAP + PADDLE_THICK);
    localparam logic [11:0] X_R   = 12'(HRES - PADDLE_GAP - PADDLE_THICK - BALL_SIZE);

    typedef enum logic [1:0] {IDLE, PLAY, SCORED, OVER} state_t;

    function automatic logic signed [12:0] sx(input logic [11:0] v);
        return {v[11], v};
    endfunction

    state_t             state_q, state_d;
    logic               fsync_q, tick_q, tick_d;
    logic [11:0]        x_q, x_d, y_q, y_d;
    logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               p1s_q, p1s_d, p2s_q, p2s_d;
    logic [11:0]        spd;
    logic signed [12:0] xs, ys, hs, vs, p1, p2, mag_x, dx, dy, nx, ny;
    logic               hit_l, hit_r;

`ifdef BALL_SPEEDUP_EN
    logic [11:0] spd_q, spd_d;
    assign spd = spd_q;
`else
    assign spd = 12'(SPD_INIT);
`endif

    assign xs    = sx(x_q);
    assign ys    = sx(y_q);
    assign hs    = sx(bus.hpos);
    assign vs    = sx(bus.vpos);
    assign p1    = sx(bus.paddle_1_vpos);
    assign p2    = sx(bus.paddle_2_vpos);
    assign mag_x = $signed({1'b0, spd});
    assign dx    = dx_neg_q ? -mag_x : mag_x;
    assign dy    = dy_neg_q ? -S_DY : S_DY;
    assign nx    = xs + dx;
    assign ny    = ys + dy;

    // The "was outside the face" term stops a ball already behind a paddle from snapping back.
    assign hit_l = dx_neg_q && (nx <= S_FL) && (xs >= S_FL) && (ny + S_BS > p2) && (ny < p2 + S_PL);
    assign hit_r = !dx_neg_q && (nx + S_BS >= S_FR) && (xs + S_BS <= S_FR) &&
                   (ny + S_BS > p1) && (ny < p1 + S_PL);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        tick_d   = bus.fsync & ~fsync_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        cnt_d    = cnt_q;
        p1s_d    = 1'b0;
        p2s_d    = 1'b0;
`ifdef BALL_SPEEDUP_EN
        spd_d    = spd_q;
`endif
        if (state_q == OVER) begin
            state_d = OVER;
        end else if (bus.player_1_win || bus.player_2_win) begin
            state_d = OVER;
        end else if (tick_q) begin
            case (state_q)
                IDLE: if (bus.serve) state_d = PLAY;
                PLAY: begin
                    x_d = nx[11:0];
                    y_d = ny[11:0];
                    if (ny <= S_ZERO)         begin y_d = '0;    dy_neg_d = 1'b0; end
                    if (ny + S_BS >= S_VRES)  begin y_d = Y_MAX; dy_neg_d = 1'b1; end
                    if (hit_l || hit_r) begin
                        x_d      = hit_l ? X_L : X_R;
                        dx_neg_d = hit_r;
`ifdef BALL_SPEEDUP_EN
                        spd_d    = (spd_q >= 12'(BALL_SPEED_MAX)) ? spd_q : spd_q + 12'd1;
`endif
                    end else if (nx[12] || (nx + S_BS > S_HRES)) begin
                        // Serve next toward whoever conceded: left exit -> ball heads left.
                        p1s_d    = nx[12];
                        p2s_d    = ~nx[12];
                        dx_neg_d = nx[12];
                        state_d  = SCORED;
`ifdef BALL_SPEEDUP_EN
                        spd_d    = 12'(SPD_INIT);
`endif
                    end
                end
                SCORED: begin
                    if (cnt_q == CW'(SERVE_DELAY - 1)) begin
                        cnt_d   = '0;
                        x_d     = CX;
                        y_d     = CY;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fsync_q  <= 1'b0;
            tick_q   <= 1'b0;
            x_q      <= CX;
            y_q      <= CY;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
            cnt_q    <= '0;
            p1s_q    <= 1'b0;
            p2s_q    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            spd_q    <= 12'(SPD_INIT);
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q  <= state_d;
            fsync_q  <= bus.fsync;
            tick_q   <= tick_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            cnt_q    <= cnt_d;
            p1s_q    <= p1s_d;
            p2s_q    <= p2s_d;
`ifdef BALL_SPEEDUP_EN
            spd_q    <= spd_d;
`endif
        end
    end

    assign bus.player_1_scored = p1s_q;
    assign bus.player_2_scored = p2s_q;
    assign bus.ball_x          = x_q;
    assign bus.ball_y          = y_q;
    assign bus.active          = ((state_q == IDLE) || (state_q == PLAY)) &&
                                 (hs >= xs) && (hs < xs + S_BS) &&
                                 (vs >= ys) && (vs < ys + S_BS);
    assign bus.pixel[0]        = bus.active ? COLOR[7:0]   : 8'h00;
    assign bus.pixel[1]        = bus.active ? COLOR[15:8]  : 8'h00;
    assign bus.pixel[2]        = bus.active ? COLOR[23:16] : 8'h00;
endmodule
